// File: rtl/atm_session_ctrl.sv
// atm_session_ctrl
// ----------------
// Session sequencer for the CryptoATM keypad path. It steers the user_input
// field parser through ACCT -> PSWD -> (auth) -> MENU -> AMOUNT -> (txn) ->
// RESULT. It runs level-held request/ack handshakes with the auth and
// transaction back ends. It also enforces an inactivity timeout, keypad
// cancel and, optionally, a failed-PIN lockout.
//
// Build option:
//   ATM_LOCKOUT_EN  - when defined, MAX_FAILS consecutive auth failures park
//                     the session in LOCKED for LOCK_CYCLES. When undefined,
//                     LOCKED is unreachable and fail_count saturates at 3.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   key_strobe        any accepted keypress (starts a session, resets idle timer)
//   key_cancel        ESC
//   field_done        parser closed a field; status_code_in/menu_sel valid with it
//   auth_ack/auth_ok  auth back-end completion and result
//   txn_ack/txn_ok    transaction back-end completion and result
//   current_state     one-hot session state (bits 15:9 always 0)
//   input_style_out   field type the parser should expect
//   auth_req/txn_req  level-held requests, dropped on the acking edge
//   txn_type          latched menu choice
//   status_code_out   last session event code
//   session_abort     one-cycle pulse on cancel or timeout
//   fail_count        consecutive auth failures
//
// state  | meaning
// -------+--------------------------------------------------
// IDLE   | no session, waiting for any keypress
// ACCT   | collecting account number
// PSWD   | collecting PIN
// AUTH   | auth request outstanding
// MENU   | collecting menu choice
// AMOUNT | collecting amount
// EXEC   | transaction request outstanding
// RESULT | showing result, any key returns to MENU
// LOCKED | lockout hold-off after too many failed PINs

module atm_session_ctrl #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int LOCK_CYCLES    = 5000,
  parameter int MAX_FAILS      = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_strobe,
  input  logic        key_cancel,
  input  logic        field_done,
  input  logic [3:0]  status_code_in,
  input  logic [1:0]  menu_sel,
  input  logic        auth_ack,
  input  logic        auth_ok,
  input  logic        txn_ack,
  input  logic        txn_ok,
  output logic [15:0] current_state,
  output logic [3:0]  input_style_out,
  output logic        auth_req,
  output logic        txn_req,
  output logic [1:0]  txn_type,
  output logic [3:0]  status_code_out,
  output logic        session_abort,
  output logic [1:0]  fail_count
);

`ifdef ATM_LOCKOUT_EN
  localparam bit LOCKOUT = 1'b1;
`else
  localparam bit LOCKOUT = 1'b0;
`endif

  localparam int TMR_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int LOCK_W = (LOCK_CYCLES > 2) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [TMR_W-1:0]  TMR_LOAD   = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LOCK_W-1:0] LOCK_LOAD  = LOCK_W'(LOCK_CYCLES - 1);
  localparam logic [1:0]        FAIL_LIMIT = 2'(MAX_FAILS);

  localparam logic [3:0] SC_OK      = 4'd0;
  localparam logic [3:0] SC_AUTH_NG = 4'd1;
  localparam logic [3:0] SC_LOCKED  = 4'd2;
  localparam logic [3:0] SC_TXN_NG  = 4'd3;
  localparam logic [3:0] SC_TIMEOUT = 4'd4;
  localparam logic [3:0] SC_CANCEL  = 4'd5;
  localparam logic [3:0] SC_BAD_FLD = 4'd6;

  typedef enum logic [8:0] {
    S_IDLE   = 9'b0_0000_0001,
    S_ACCT   = 9'b0_0000_0010,
    S_PSWD   = 9'b0_0000_0100,
    S_AUTH   = 9'b0_0000_1000,
    S_MENU   = 9'b0_0001_0000,
    S_AMOUNT = 9'b0_0010_0000,
    S_EXEC   = 9'b0_0100_0000,
    S_RESULT = 9'b0_1000_0000,
    S_LOCKED = 9'b1_0000_0000
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   idle_tmr_q;
  logic [LOCK_W-1:0]  lock_tmr_q;
  logic [1:0]         fail_d, type_d, fail_inc;
  logic [3:0]         code_d, style_d;
  logic               abort_d, auth_req_d, txn_req_d;
  logic               active, cancel_evt, timeout_evt, field_ok, field_bad;

  // Keypad-driven states: only these honour cancel and run the idle timer.
  assign active      = state_q inside {S_ACCT, S_PSWD, S_MENU, S_AMOUNT, S_RESULT};
  assign cancel_evt  = active & key_cancel;
  assign timeout_evt = active & ~key_strobe & (idle_tmr_q == '0);
  assign field_ok    = field_done & (status_code_in == 4'd0);
  assign field_bad   = field_done & (status_code_in != 4'd0);
  // Saturating increment; with lockout enabled the count never passes MAX_FAILS.
  assign fail_inc    = (fail_count == 2'd3) ? 2'd3 : fail_count + 2'd1;

  assign current_state = {7'd0, state_q};

  // State register, timers and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      idle_tmr_q      <= '0;
      lock_tmr_q      <= '0;
      input_style_out <= 4'd0;
      auth_req        <= 1'b0;
      txn_req         <= 1'b0;
      txn_type        <= 2'd0;
      status_code_out <= 4'd0;
      session_abort   <= 1'b0;
      fail_count      <= 2'd0;
    end else begin
      state_q         <= state_d;
      input_style_out <= style_d;
      auth_req        <= auth_req_d;
      txn_req         <= txn_req_d;
      txn_type        <= type_d;
      status_code_out <= code_d;
      session_abort   <= abort_d;
      fail_count      <= fail_d;

      // Idle timer is held at its load value outside the keypad states,
      // so every session phase starts with a full timeout window.
      if (!active || key_strobe)
        idle_tmr_q <= TMR_LOAD;
      else if (idle_tmr_q != '0)
        idle_tmr_q <= idle_tmr_q - 1'b1;

      if (state_q != S_LOCKED)
        lock_tmr_q <= LOCK_LOAD;
      else if (lock_tmr_q != '0)
        lock_tmr_q <= lock_tmr_q - 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    fail_d  = fail_count;
    type_d  = txn_type;
    code_d  = status_code_out;
    abort_d = 1'b0;

    if (cancel_evt) begin
      state_d = S_IDLE;
      code_d  = SC_CANCEL;
      abort_d = 1'b1;
    end else if (timeout_evt) begin
      state_d = S_IDLE;
      code_d  = SC_TIMEOUT;
      abort_d = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (key_strobe) state_d = S_ACCT;
        end
        S_ACCT: begin
          if (field_ok)       state_d = S_PSWD;
          else if (field_bad) code_d  = SC_BAD_FLD;
        end
        S_PSWD: begin
          if (field_ok)       state_d = S_AUTH;
          else if (field_bad) code_d  = SC_BAD_FLD;
        end
        S_AUTH: begin
          if (auth_ack) begin
            if (auth_ok) begin
              fail_d  = 2'd0;
              state_d = S_MENU;
            end else begin
              fail_d = fail_inc;
              if (LOCKOUT && (fail_inc == FAIL_LIMIT)) begin
                state_d = S_LOCKED;
                code_d  = SC_LOCKED;
              end else begin
                state_d = S_ACCT;
                code_d  = SC_AUTH_NG;
              end
            end
          end
        end
        S_MENU: begin
          if (field_ok) begin
            type_d  = menu_sel;
            // Balance enquiry needs no amount field.
            state_d = (menu_sel == 2'b00) ? S_EXEC : S_AMOUNT;
          end else if (field_bad) begin
            code_d = SC_BAD_FLD;
          end
        end
        S_AMOUNT: begin
          if (field_ok)       state_d = S_EXEC;
          else if (field_bad) code_d  = SC_BAD_FLD;
        end
        S_EXEC: begin
          if (txn_ack) begin
            state_d = S_RESULT;
            code_d  = txn_ok ? SC_OK : SC_TXN_NG;
          end
        end
        S_RESULT: begin
          if (key_strobe) state_d = S_MENU;
        end
        S_LOCKED: begin
          if (lock_tmr_q == '0) begin
            state_d = S_IDLE;
            fail_d  = 2'd0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output decode from the next state, so outputs move with the state register
  always_comb begin
    style_d    = 4'b0000;
    auth_req_d = (state_d == S_AUTH);
    txn_req_d  = (state_d == S_EXEC);
    case (state_d)
      S_ACCT:   style_d = 4'b0001;
      S_PSWD:   style_d = 4'b0010;
      S_MENU:   style_d = 4'b0100;
      S_AMOUNT: style_d = 4'b1000;
      default:  style_d = 4'b0000;
    endcase
  end

endmodule

// File: tb/tb_atm_session_ctrl.sv
module tb_atm_session_ctrl;
  localparam int TO = 1000;
  localparam int LK = 5000;
  localparam int MF = 3;

`ifdef ATM_LOCKOUT_EN
  localparam bit LOCKOUT = 1'b1;
`else
  localparam bit LOCKOUT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_strobe = 1'b0, key_cancel = 1'b0, field_done = 1'b0;
  logic [3:0]  status_code_in = 4'd0;
  logic [1:0]  menu_sel = 2'd0;
  logic        auth_ack = 1'b0, auth_ok = 1'b0, txn_ack = 1'b0, txn_ok = 1'b0;
  logic [15:0] current_state;
  logic [3:0]  input_style_out;
  logic        auth_req, txn_req;
  logic [1:0]  txn_type;
  logic [3:0]  status_code_out;
  logic        session_abort;
  logic [1:0]  fail_count;

  atm_session_ctrl #(.TIMEOUT_CYCLES(TO), .LOCK_CYCLES(LK), .MAX_FAILS(MF)) dut (
    .clk(clk), .rst_n(rst_n), .key_strobe(key_strobe), .key_cancel(key_cancel),
    .field_done(field_done), .status_code_in(status_code_in), .menu_sel(menu_sel),
    .auth_ack(auth_ack), .auth_ok(auth_ok), .txn_ack(txn_ack), .txn_ok(txn_ok),
    .current_state(current_state), .input_style_out(input_style_out),
    .auth_req(auth_req), .txn_req(txn_req), .txn_type(txn_type),
    .status_code_out(status_code_out), .session_abort(session_abort),
    .fail_count(fail_count));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: state as a phase number 0..8 (IDLE..LOCKED), idle time and lock
  // time as elapsed-cycle counts.
  int m_st = 0, m_idle = 0, m_lock = 0, m_fails = 0, m_type = 0, m_code = 0;
  bit m_abort = 0;

  task automatic model_step();
    bit act;
    if (!rst_n) begin
      m_st = 0; m_idle = 0; m_lock = 0; m_fails = 0; m_type = 0; m_code = 0; m_abort = 0;
      return;
    end
    act = (m_st == 1 || m_st == 2 || m_st == 4 || m_st == 5 || m_st == 7);
    m_abort = 0;
    if (act && key_cancel) begin
      m_st = 0; m_code = 5; m_abort = 1;
    end else if (act && !key_strobe && m_idle == TO - 1) begin
      m_st = 0; m_code = 4; m_abort = 1;
    end else begin
      case (m_st)
        0: if (key_strobe) m_st = 1;
        1, 2, 5: if (field_done) begin
          if (status_code_in == 0) m_st = (m_st == 1) ? 2 : (m_st == 2) ? 3 : 6;
          else m_code = 6;
        end
        3: if (auth_ack) begin
          if (auth_ok) begin
            m_fails = 0; m_st = 4;
          end else begin
            m_fails = (m_fails < 3) ? m_fails + 1 : 3;
            if (LOCKOUT && m_fails == MF) begin
              m_st = 8; m_code = 2; m_lock = 0;
            end else begin
              m_st = 1; m_code = 1;
            end
          end
        end
        4: if (field_done) begin
          if (status_code_in == 0) begin
            m_type = int'(menu_sel);
            m_st = (menu_sel == 0) ? 6 : 5;
          end else m_code = 6;
        end
        6: if (txn_ack) begin
          m_st = 7; m_code = txn_ok ? 0 : 3;
        end
        7: if (key_strobe) m_st = 4;
        8: begin
          m_lock++;
          if (m_lock == LK) begin
            m_st = 0; m_fails = 0;
          end
        end
        default: m_st = 0;
      endcase
    end
    m_idle = (act && !key_strobe) ? m_idle + 1 : 0;
  endtask

  function automatic logic [3:0] exp_style(input int st);
    case (st)
      1: return 4'b0001;
      2: return 4'b0010;
      4: return 4'b0100;
      5: return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [15:0] es;
    model_step();
    #1;
    es = 16'h0001 << m_st;
    tests++;
    if (current_state !== es || input_style_out !== exp_style(m_st) ||
        auth_req !== (m_st == 3) || txn_req !== (m_st == 6) ||
        txn_type !== 2'(m_type) || status_code_out !== 4'(m_code) ||
        session_abort !== m_abort || fail_count !== 2'(m_fails)) begin
      fails++;
      $display("FAIL model_cmp t=%0t state %h/%h style %b/%b areq %b/%b treq %b/%b type %0d/%0d code %0d/%0d abort %b/%b fails %0d/%0d (got/want)",
               $time, current_state, es, input_style_out, exp_style(m_st),
               auth_req, (m_st == 3), txn_req, (m_st == 6), txn_type, m_type,
               status_code_out, m_code, session_abort, m_abort, fail_count, m_fails);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    key_strobe = 0; key_cancel = 0; field_done = 0; auth_ack = 0; txn_ack = 0;
  endtask

  task automatic field(input logic [3:0] sc, input logic [1:0] ms, input logic ks);
    status_code_in = sc; menu_sel = ms; field_done = 1; key_strobe = ks;
    step();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_state", int'(current_state), 'h0001);
    chk("reset_style", int'(input_style_out), 0);
    chk("reset_code", int'(status_code_out), 0);
    chk("reset_fails", int'(fail_count), 0);
    rst_n = 1;
    step();

    // happy path: withdraw
    key_strobe = 1; step();
    chk("hp_acct", int'(current_state), 'h0002);
    chk("hp_acct_style", int'(input_style_out), 1);
    field(0, 0, 1); chk("hp_pswd", int'(current_state), 'h0004);
    field(0, 0, 1); chk("hp_auth", int'(current_state), 'h0008);
    chk("hp_auth_req", int'(auth_req), 1);
    auth_ack = 1; auth_ok = 1; step();
    chk("hp_menu", int'(current_state), 'h0010);
    chk("hp_auth_req_drop", int'(auth_req), 0);
    field(0, 2'b01, 1); chk("hp_amount", int'(current_state), 'h0020);
    field(0, 0, 1); chk("hp_exec", int'(current_state), 'h0040);
    chk("hp_txn_req", int'(txn_req), 1);
    txn_ack = 1; txn_ok = 1; step();
    chk("hp_result", int'(current_state), 'h0080);
    chk("hp_txn_type", int'(txn_type), 1);
    chk("hp_code", int'(status_code_out), 0);

    // balance shortcut, stray ack ignored, failed transaction
    key_strobe = 1; step();
    txn_ack = 1; txn_ok = 1; step();
    chk("stray_ack", int'(current_state), 'h0010);
    field(0, 2'b00, 1); chk("bal_exec", int'(current_state), 'h0040);
    chk("bal_type", int'(txn_type), 0);
    txn_ack = 1; txn_ok = 0; step();
    chk("txn_ng_code", int'(status_code_out), 3);
    key_strobe = 1; step();

    // cancel beats field_done in MENU
    key_cancel = 1; field(0, 2'b10, 0);
    chk("cancel_state", int'(current_state), 'h0001);
    chk("cancel_code", int'(status_code_out), 5);
    chk("cancel_abort", int'(session_abort), 1);
    step();
    chk("cancel_abort_1cyc", int'(session_abort), 0);

    // bad field in ACCT
    key_strobe = 1; step();
    field(4'h2, 0, 0);
    chk("bad_state", int'(current_state), 'h0002);
    chk("bad_code", int'(status_code_out), 6);

    // timeout in PSWD
    field(0, 0, 1);
    repeat (TO - 1) step();
    chk("to_before", int'(current_state), 'h0004);
    step();
    chk("to_state", int'(current_state), 'h0001);
    chk("to_code", int'(status_code_out), 4);
    chk("to_abort", int'(session_abort), 1);
    step();
    chk("to_abort_1cyc", int'(session_abort), 0);

    // consecutive auth failures
    key_strobe = 1; step();
    for (int i = 1; i <= 3; i++) begin
      field(0, 0, 1); field(0, 0, 1);
      auth_ack = 1; auth_ok = 0; step();
      chk("lk_count", int'(fail_count), i);
      if (i < 3) chk("lk_code", int'(status_code_out), 1);
    end
`ifdef ATM_LOCKOUT_EN
    chk("lk_locked", int'(current_state), 'h0100);
    chk("lk_code2", int'(status_code_out), 2);
    repeat (LK - 1) step();
    chk("lk_hold", int'(current_state), 'h0100);
    step();
    chk("lk_release", int'(current_state), 'h0001);
    chk("lk_clear", int'(fail_count), 0);
    key_strobe = 1; step();
`else
    chk("nolk_acct", int'(current_state), 'h0002);
    chk("nolk_code", int'(status_code_out), 1);
    field(0, 0, 1); field(0, 0, 1);
    auth_ack = 1; auth_ok = 0; step();
    chk("nolk_sat", int'(fail_count), 3);
`endif

    // cancel ignored during AUTH
    field(0, 0, 1); field(0, 0, 1);
    key_cancel = 1; step();
    chk("auth_cancel_state", int'(current_state), 'h0008);
    chk("auth_cancel_req", int'(auth_req), 1);
    step();
    auth_ack = 1; auth_ok = 1; step();
    chk("auth_done", int'(current_state), 'h0010);
    chk("auth_fail_clr", int'(fail_count), 0);

    // reset mid-handshake
    field(0, 2'b00, 1);
    chk("rst_exec", int'(txn_req), 1);
    rst_n = 0; step();
    chk("rst_req_drop", int'(txn_req), 0);
    chk("rst_state", int'(current_state), 'h0001);
    rst_n = 1; step();
    txn_ack = 1; txn_ok = 1; step();
    chk("rst_ack_ignored", int'(current_state), 'h0001);

    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/atm_session_ctrl.md
# atm_session_ctrl

Session sequencer for the CryptoATM keypad path. It owns the one-hot `current_state` and `input_style_out` vectors that steer the `user_input` field parser. It advances on parser field-completion strobes and runs request/acknowledge handshakes with the account-authentication and transaction back ends. It also enforces an inactivity timeout, keypad cancel, and a failed-PIN lockout.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 1000: idle cycles (no `key_strobe`) before the session is aborted.
- `LOCK_CYCLES`, 5000: cycles spent in LOCKED before returning to IDLE.
- `MAX_FAILS`, 3: consecutive auth failures that trigger a lockout; legal range 1–3.

Ports:
- `clk` in 1: the single clock; everything is rising-edge.
- `rst_n` in 1: synchronous reset, active-low.
- `key_strobe` in 1: one-cycle pulse on any accepted keypress.
- `key_cancel` in 1: one-cycle pulse when ESC is pressed.
- `field_done` in 1: one-cycle pulse from `user_input` when Enter closes a field.
- `status_code_in` in 4: parser status, sampled with `field_done`; 0 = field valid.
- `menu_sel` in 2: menu choice, sampled with `field_done` in MENU. 00 = balance, 01 = withdraw, 10 = deposit, 11 = transfer.
- `auth_ack` in 1: one-cycle pulse completing an auth request.
- `auth_ok` in 1: auth result, sampled with `auth_ack`.
- `txn_ack` in 1: one-cycle pulse completing a transaction request.
- `txn_ok` in 1: transaction result, sampled with `txn_ack`.
- `current_state` out 16: one-hot state vector (see Operation).
- `input_style_out` out 4: field type expected from the parser.
- `auth_req` out 1: auth request, level-held until `auth_ack`.
- `txn_req` out 1: transaction request, level-held until `txn_ack`.
- `txn_type` out 2: copy of the latched `menu_sel`; stable while `txn_req` is high.
- `status_code_out` out 4: last session event code.
- `session_abort` out 1: one-cycle pulse on timeout or cancel.
- `fail_count` out 2: current consecutive auth failure count.

## Operation
`current_state` one-hot bit assignment:
- bit0 IDLE, bit1 ACCT, bit2 PSWD, bit3 AUTH, bit4 MENU, bit5 AMOUNT, bit6 EXEC, bit7 RESULT, bit8 LOCKED.
- bits 15:9 are always 0.

`input_style_out` per state:
- ACCT 0001, PSWD 0010, MENU 0100, AMOUNT 1000.
- 0000 in every other state.

Transitions:
- IDLE → ACCT on `key_strobe`.
- ACCT → PSWD on `field_done` with `status_code_in` == 0.
- PSWD → AUTH on `field_done` with `status_code_in` == 0.
- AUTH: `auth_req` = 1. On `auth_ack`:
  - if `auth_ok` = 1: `fail_count` clears to 0, go to MENU.
  - if `auth_ok` = 0: `fail_count` increments, `status_code_out` = 1. If the new count equals `MAX_FAILS`, go to LOCKED with `status_code_out` = 2; otherwise go to ACCT.
- MENU, on `field_done` with `status_code_in` == 0: latch `menu_sel` into `txn_type`. Go to EXEC if the choice is 00 (balance); otherwise go to AMOUNT.
- AMOUNT → EXEC on `field_done` with `status_code_in` == 0.
- EXEC: `txn_req` = 1. On `txn_ack`, go to RESULT; `status_code_out` = 0 if `txn_ok` = 1, else 3.
- RESULT → MENU on the next `key_strobe`.
- LOCKED: counts `LOCK_CYCLES`, then goes to IDLE. `fail_count` clears on entry to IDLE from LOCKED only.

Field errors and aborts:
- `field_done` with `status_code_in` ≠ 0: stay in the current state, `status_code_out` = 6.
- `key_cancel` in ACCT/PSWD/MENU/AMOUNT/RESULT: go to IDLE, `status_code_out` = 5, `session_abort` pulses.
- Inactivity timer: resets on any `key_strobe`. It runs only in ACCT/PSWD/MENU/AMOUNT/RESULT, and clears whenever the state is outside that set. On reaching `TIMEOUT_CYCLES`: go to IDLE, `status_code_out` = 4, `session_abort` pulses.
- Event priority: reset > cancel > timeout > `field_done`.
- `key_cancel` and timeout are ignored in AUTH and EXEC; the handshake always completes.
- In IDLE and LOCKED, all keypad inputs are ignored except that `key_strobe` starts a session from IDLE.

## Timing
- Reset values: `current_state` = 16'h0001, `input_style_out` = 0, `auth_req` = 0, `txn_req` = 0, `txn_type` = 0, `status_code_out` = 0, `session_abort` = 0, `fail_count` = 0. All counters are 0.
- All outputs are registered and change on the same edge as the state register.
- Input sampled at edge N → new state and outputs visible after edge N.
- `auth_req` and `txn_req` rise on the edge that enters AUTH/EXEC and fall on the edge that samples the ack. An ack arriving while the matching request is low is ignored.
- `session_abort` is high for exactly one cycle.
- Timeout fires on the edge at which the timer value reaches `TIMEOUT_CYCLES` − 1.
- Reset asserted mid-handshake drops the request on the next edge; no completion is required.

## Configuration
- `ATM_LOCKOUT_EN` defined: behaviour as above.
- `ATM_LOCKOUT_EN` undefined:
  - a failed auth always returns to ACCT;
  - LOCKED is unreachable and bit8 is always 0;
  - `fail_count` saturates at 3;
  - `status_code_out` = 2 is never produced.

## Test plan
- Happy path: reset; `key_strobe`; valid ACCT and PSWD fields; `auth_ack` with `auth_ok` = 1; `menu_sel` = 01; valid AMOUNT; `txn_ack` with `txn_ok` = 1 → state sequence 0001, 0002, 0004, 0008, 0010, 0020, 0040, 0080; `txn_type` = 01; `status_code_out` = 0.
- Lockout: three auth failures in a row → `fail_count` 1, 2, 3; state goes to 0100; after 5000 cycles state = 0001 and `fail_count` = 0. Without `ATM_LOCKOUT_EN`, the third failure returns to 0002.
- Timeout: enter PSWD, then no keys for 1000 cycles → state 0001, `status_code_out` = 4, one-cycle `session_abort`.
- Cancel vs. field: `key_cancel` and `field_done` in the same cycle in MENU → state 0001, `status_code_out` = 5. Cancel issued during AUTH → ignored; `auth_req` stays high until `auth_ack`.
- Bad field: `field_done` with `status_code_in` = 4'h2 in ACCT → state remains 0002, `status_code_out` = 6.
- Balance shortcut: MENU with `menu_sel` = 00 → state goes directly to EXEC (0040), `txn_type` = 00.
